hazard_fwd_unit: RTL
====================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard/forwarding unit for the pipelined MIPS core; tracks in-flight writers itself.
//  Keeps a shift pipe of {A3, Tnew} for NUM_STAGES stages after ID (1=EX, 2=MEM, 3=WB by default).
//  Generates ID- and EX-stage forward selects for NUM_RD_PORTS operands and the Tuse/Tnew stall.
//  Also generates a multi-cycle MDU busy stall for mfhi/mflo/mult/div.
// PARAMETERS
//  NUM_STAGES    3  writer stages tracked after ID (>=2)
//  NUM_RD_PORTS  2  source operands per instruction
//  REG_AW        5  register address width
//  TW            2  Tnew/Tuse width
//  MDU_LAT       5  MDU busy cycles after mult/div enters EX (>=1)
// PORTS
//  clk          in   1                        clock
//  reset        in   1                        synchronous, active-high
//  flush        in   1                        kill instruction in ID (no entry into EX)
//  id_rs        in   NUM_RD_PORTS x REG_AW    ID source addresses
//  id_tuse      in   NUM_RD_PORTS x TW        cycles until each source is consumed (0 = ID)
//  id_a3        in   REG_AW                   ID destination (0 = no write)
//  id_tnew      in   TW                       cycles until result exists, counted from EX
//  id_md_start  in   1                        ID instr is mult/div
//  id_md_use    in   1                        ID instr needs MDU (mfhi/mflo/mthi/mtlo/mult/div)
//  stall        out  1                        freeze PC/IF-ID, insert bubble into EX
//  id_fwd_sel   out  NUM_RD_PORTS x SELW      0 = regfile, s = result of stage s
//  ex_fwd_sel   out  NUM_RD_PORTS x SELW      0 = ID-read value, s = result of stage s (s>=2)
//  perf_stall_cnt  out  32                    total stall cycles (HAZARD_PERF_EN)
//  perf_md_cnt     out  32                    MDU stall cycles (HAZARD_PERF_EN)
//  SELW = $clog2(NUM_STAGES+1)
// BEHAVIOUR
//  Pipe entry per stage: a3, tnew, rs[NUM_RD_PORTS] (rs only needed in stage 1).
//  Reset: all entries a3=0, tnew=0, rs=0; MDU counter=0; perf counters=0.
//  Reset outputs: stall=0; all selects=0.
//  Each cycle, stage s+1 <= stage s with tnew saturating-decremented (0 stays 0).
//  Stage 1 loads: bubble (all 0) on stall|flush, else {id_a3, id_tnew, id_rs}.
//  Match(p,s): rs!=0 && rs==a3_s. Youngest (lowest s) match wins; older matches are ignored.
//  stall_data: any port p whose youngest ID match has tnew_s > id_tuse[p].
//  id_fwd_sel[p] = s if the youngest match has tnew_s==0, else 0.
//  ex_fwd_sel[p]: youngest match of stage-1 rs[p] among s=2..N with tnew_s==0, else 0.
//  MDU: counter loads MDU_LAT when a mult/div enters stage 1, else decrements to 0.
//  MDU: busy = counter!=0. stall_md = id_md_use && busy.
//  stall = (stall_data | stall_md) & ~flush; all outputs combinational from registered state + ID inputs.
//  Latency: a stalled instruction re-evaluates every cycle; no extra cycle after hazard clears.
//  A bubble never matches; $0 never forwards nor stalls.
//  Reset mid-stall: next cycle stall=0 and the pipe is empty.
// CONFIGURATION
//  HAZARD_PERF_EN defined: perf_stall_cnt +1 per stall cycle.
//  HAZARD_PERF_EN defined: perf_md_cnt +1 per cycle with stall_md. Both wrap at 2^32.
//  HAZARD_PERF_EN undefined: both outputs tied to 0, no counter flops.
// STRUCTURE
//  hazard_pkg: REG_AW/TW defaults, reg_addr_t, tnew_t, stage_entry_t struct {a3, tnew, rs[]}.
//  hazard_pkg also holds the FWD_RF=0 constant.
//  Sub-module hazard_stage_pipe: the entry shift register with bubble insertion and Tnew decrement.
//  Top level: match/priority logic, MDU counter, perf counters.
// TESTING
//  lw $2 (tnew2) then addu rs=$2 (tuse1): stall=1 for 1 cycle; next cycle id_fwd_sel=0.
//  lw $2 / addu $2 case, continued: a cycle later, in EX, ex_fwd_sel=3.
//  addu $4 (tnew1) then beq rs=$4 (tuse0): stall 1 cycle, then id_fwd_sel=2, stall=0.
//  lui $5 (tnew0) then addu rs=$5: no stall, id_fwd_sel=1.
//  Writes to $5 in stages 1 and 2 both tnew0: id_fwd_sel=1 (youngest wins).
//  a3=$0 writer followed by rs=$0: no stall, sel=0.
//  mult then mflo, MDU_LAT=5: stall=1 for exactly 5 cycles.
//  mult/mflo again, with flush asserted in cycle 3: stall=0 that cycle, bubble enters EX.
//  With HAZARD_PERF_EN: perf_md_cnt=4 (5 minus the flushed cycle).
//  Reset during a lw-use stall: next cycle stall=0, all selects 0, perf counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Optional performance counters in the top level are enabled by defining HAZARD_PERF_EN.
package hazard_pkg;

  localparam int HZ_REG_AW       = 5;
  localparam int HZ_TW           = 2;
  localparam int HZ_NUM_RD_PORTS = 2;

  // A forward select of FWD_RF means "take the register-file / ID-read value"
  localparam int FWD_RF = 0;

  typedef logic [HZ_REG_AW-1:0] reg_addr_t;
  typedef logic [HZ_TW-1:0]     tnew_t;

  typedef struct packed {
    reg_addr_t                         a3;
    tnew_t                             tnew;
    reg_addr_t [HZ_NUM_RD_PORTS-1:0]   rs;
  } stage_entry_t;

endpackage

// File: rtl/hazard_stage_pipe.sv
// Shift register of in-flight writers {a3, tnew} for stages 1..NUM_STAGES after ID.
// Stage 1 also keeps the source addresses of the instruction now in EX.
module hazard_stage_pipe
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = HZ_NUM_RD_PORTS,
  parameter int REG_AW       = HZ_REG_AW,
  parameter int TW           = HZ_TW
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_bubble,
  input  logic [REG_AW-1:0]                     i_a3,
  input  logic [TW-1:0]                         i_tnew,
  input  logic [NUM_RD_PORTS-1:0][REG_AW-1:0]   i_rs,
  output logic [NUM_STAGES:1][REG_AW-1:0]       o_a3,
  output logic [NUM_STAGES:1][TW-1:0]           o_tnew,
  output logic [NUM_RD_PORTS-1:0][REG_AW-1:0]   o_rs1
);

  logic [NUM_STAGES:1][REG_AW-1:0]     r_a3;
  logic [NUM_STAGES:1][TW-1:0]         r_tnew;
  logic [NUM_RD_PORTS-1:0][REG_AW-1:0] r_rs1;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a3   <= '0;
      r_tnew <= '0;
      r_rs1  <= '0;
    end else begin
      if (i_bubble) begin
        r_a3[1]   <= '0;
        r_tnew[1] <= '0;
        r_rs1     <= '0;
      end else begin
        r_a3[1]   <= i_a3;
        r_tnew[1] <= i_tnew;
        r_rs1     <= i_rs;
      end
      // Older stages age by one cycle; a result that already exists stays at 0
      for (int s = 2; s <= NUM_STAGES; s++) begin
        r_a3[s]   <= r_a3[s-1];
        r_tnew[s] <= sat_dec(r_tnew[s-1]);
      end
    end
  end

  assign o_a3   = r_a3;
  assign o_tnew = r_tnew;
  assign o_rs1  = r_rs1;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: youngest-match forwarding for ID and EX, Tuse/Tnew and MDU stalls.
// Define HAZARD_PERF_EN to build the stall performance counters; otherwise they read 0.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RD_PORTS = HZ_NUM_RD_PORTS,
  parameter int REG_AW       = HZ_REG_AW,
  parameter int TW           = HZ_TW,
  parameter int MDU_LAT      = 5
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              flush,
  input  logic [NUM_RD_PORTS-1:0][REG_AW-1:0]               id_rs,
  input  logic [NUM_RD_PORTS-1:0][TW-1:0]                   id_tuse,
  input  logic [REG_AW-1:0]                                 id_a3,
  input  logic [TW-1:0]                                     id_tnew,
  input  logic                                              id_md_start,
  input  logic                                              id_md_use,
  output logic                                              stall,
  output logic [NUM_RD_PORTS-1:0][$clog2(NUM_STAGES+1)-1:0] id_fwd_sel,
  output logic [NUM_RD_PORTS-1:0][$clog2(NUM_STAGES+1)-1:0] ex_fwd_sel,
  output logic [31:0]                                       perf_stall_cnt,
  output logic [31:0]                                       perf_md_cnt
);

  localparam int SELW = $clog2(NUM_STAGES+1);
  localparam int CW   = $clog2(MDU_LAT+1);

  logic [NUM_STAGES:1][REG_AW-1:0]     w_a3;
  logic [NUM_STAGES:1][TW-1:0]         w_tnew;
  logic [NUM_RD_PORTS-1:0][REG_AW-1:0] w_rs1;

  logic [NUM_RD_PORTS-1:0]             w_id_hit;
  logic [NUM_RD_PORTS-1:0][TW-1:0]     w_id_tnew;
  logic [NUM_RD_PORTS-1:0][SELW-1:0]   w_id_stage;
  logic [NUM_RD_PORTS-1:0]             w_ex_hit;
  logic [NUM_RD_PORTS-1:0][TW-1:0]     w_ex_tnew;
  logic [NUM_RD_PORTS-1:0][SELW-1:0]   w_ex_stage;

  logic          w_stall_data;
  logic          w_stall_md;
  logic          w_md_busy;
  logic          w_bubble;
  logic          w_md_enter;
  logic [CW-1:0] r_md_cnt;

  hazard_stage_pipe #(
    .NUM_STAGES   (NUM_STAGES),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .REG_AW       (REG_AW),
    .TW           (TW)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .i_bubble (w_bubble),
    .i_a3     (id_a3),
    .i_tnew   (id_tnew),
    .i_rs     (id_rs),
    .o_a3     (w_a3),
    .o_tnew   (w_tnew),
    .o_rs1    (w_rs1)
  );

  // Scanning oldest to youngest lets the youngest match overwrite older ones
  always_comb begin
    w_id_hit   = '0;
    w_id_tnew  = '0;
    w_id_stage = '0;
    w_ex_hit   = '0;
    w_ex_tnew  = '0;
    w_ex_stage = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int s = NUM_STAGES; s >= 1; s--) begin
        if (id_rs[p] != '0 && id_rs[p] == w_a3[s]) begin
          w_id_hit[p]   = 1'b1;
          w_id_tnew[p]  = w_tnew[s];
          w_id_stage[p] = SELW'(s);
        end
      end
      for (int s = NUM_STAGES; s >= 2; s--) begin
        if (w_rs1[p] != '0 && w_rs1[p] == w_a3[s]) begin
          w_ex_hit[p]   = 1'b1;
          w_ex_tnew[p]  = w_tnew[s];
          w_ex_stage[p] = SELW'(s);
        end
      end
    end
  end

  always_comb begin
    w_stall_data = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      id_fwd_sel[p] = SELW'(FWD_RF);
      ex_fwd_sel[p] = SELW'(FWD_RF);
      if (w_id_hit[p] && (w_id_tnew[p] > id_tuse[p])) begin
        w_stall_data = 1'b1;
      end
      if (w_id_hit[p] && (w_id_tnew[p] == '0)) begin
        id_fwd_sel[p] = w_id_stage[p];
      end
      if (w_ex_hit[p] && (w_ex_tnew[p] == '0)) begin
        ex_fwd_sel[p] = w_ex_stage[p];
      end
    end
  end

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_stall_md = id_md_use & w_md_busy;
  assign stall      = (w_stall_data | w_stall_md) & ~flush;
  assign w_bubble   = stall | flush;
  assign w_md_enter = id_md_start & ~w_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_md_enter) begin
      r_md_cnt <= CW'(MDU_LAT);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_md_cnt;

  // A flushed cycle is not a stall cycle, even if the MDU is still busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_md_cnt    <= '0;
    end else begin
      if (stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (w_stall_md && !flush) begin
        r_perf_md_cnt <= r_perf_md_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_md_cnt    = r_perf_md_cnt;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_md_cnt    = 32'd0;
`endif

endmodule
